// File: rtl/kw_stream_pkg.sv
// Shared helpers for the kw_stream arbiter family: id width derivation and the default id type.
package kw_stream_pkg;

  // Bits needed to index n items, never less than one.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  localparam int KW_DEFAULT_N_REQ = 4;

  typedef logic [clog2_min1(KW_DEFAULT_N_REQ)-1:0] kw_id_t;

endpackage

// File: rtl/kw_rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping modulo N.
// Zero latency; no backpressure (pure function of req_i and ptr_i).
module kw_rr_pick
  import kw_stream_pkg::*;
#(
  parameter  int N   = 4,
  localparam int IDW = clog2_min1(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [IDW-1:0] gnt_id_o,
  output logic           any_o
);

  logic [2*N-1:0] req_dbl;
  logic [2*N-1:0] mask;
  logic [2*N-1:0] cand;
  logic           found;

  // Doubling the request vector turns the wrap-around search into a plain
  // lowest-set-bit search over the window [ptr, ptr+N-1].
  assign req_dbl = {req_i, req_i};

  always_comb begin
    mask = '0;
    for (int i = 0; i < 2 * N; i++) begin
      mask[i] = (i >= int'(ptr_i));
    end
  end

  assign cand = req_dbl & mask;

  always_comb begin
    gnt_id_o = '0;
    found    = 1'b0;
    for (int i = 0; i < 2 * N; i++) begin
      if (cand[i] && !found) begin
        found    = 1'b1;
        gnt_id_o = IDW'((i >= N) ? (i - N) : i);
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/kw_stream_rr_arbiter.sv
// N-way round-robin merge of ready/valid streams with optional packet lock; registered output, 1-cycle latency.
// Backpressure: o_valid && !o_ready holds the output stable and drives every i_ready low.
module kw_stream_rr_arbiter
  import kw_stream_pkg::*;
#(
  parameter  int N_REQ        = 4,
  parameter  int DATA_WIDTH   = 16,
  parameter  bit LOCK_PACKETS = 1'b1,
  localparam int ID_WIDTH     = clog2_min1(N_REQ)
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [N_REQ-1:0]            i_valid,
  output logic [N_REQ-1:0]            i_ready,
  input  logic [N_REQ-1:0]            i_last,
  input  logic [N_REQ*DATA_WIDTH-1:0] i_data,
  output logic                        o_valid,
  input  logic                        o_ready,
  output logic [DATA_WIDTH-1:0]       o_data,
  output logic                        o_last,
  output logic [ID_WIDTH-1:0]         o_id
);

  logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
  logic                  lock_q, lock_d;
  logic [ID_WIDTH-1:0]   lock_id_q, lock_id_d;
  logic                  o_valid_q, o_valid_d;
  logic [DATA_WIDTH-1:0] o_data_q, o_data_d;
  logic                  o_last_q, o_last_d;
  logic [ID_WIDTH-1:0]   o_id_q, o_id_d;

  logic [ID_WIDTH-1:0]   pick_id;
  logic                  pick_any;
  logic [ID_WIDTH-1:0]   gnt_id;
  logic                  any_cand;
  logic                  load_en;
  logic                  gnt_valid;
  logic                  gnt_last;
  logic [DATA_WIDTH-1:0] gnt_data;
  logic                  xfer;

  kw_rr_pick #(
    .N (N_REQ)
  ) u_pick (
    .req_i    (i_valid),
    .ptr_i    (ptr_q),
    .gnt_id_o (pick_id),
    .any_o    (pick_any)
  );

  assign load_en  = !o_valid_q || o_ready;
  assign gnt_id   = lock_q ? lock_id_q : pick_id;
  assign any_cand = lock_q || pick_any;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_last  = 1'b0;
    gnt_data  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt_id == ID_WIDTH'(k)) begin
        gnt_valid = i_valid[k];
        gnt_last  = i_last[k];
        gnt_data  = i_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Gated by reset_n: during reset the picker still sees live valids and would otherwise offer a grant.
  always_comb begin
    i_ready = '0;
    if (reset_n && load_en && any_cand) begin
      for (int k = 0; k < N_REQ; k++) begin
        i_ready[k] = (gnt_id == ID_WIDTH'(k));
      end
    end
  end

  assign xfer = reset_n && load_en && any_cand && gnt_valid;

  always_comb begin
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    o_last_d  = o_last_q;
    o_id_d    = o_id_q;
    ptr_d     = ptr_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (xfer) begin
      o_valid_d = 1'b1;
      o_data_d  = gnt_data;
      o_last_d  = gnt_last;
      o_id_d    = gnt_id;
      if (!LOCK_PACKETS || gnt_last) begin
        ptr_d = (gnt_id == ID_WIDTH'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
      end
      // A locked requester keeps the grant even with i_valid low; the output simply drains.
      if (LOCK_PACKETS) begin
        lock_d    = !gnt_last;
        lock_id_d = gnt_id;
      end
    end else if (load_en) begin
      o_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q     <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_last_q  <= 1'b0;
      o_id_q    <= '0;
    end else begin
      ptr_q     <= ptr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_last_q  <= o_last_d;
      o_id_q    <= o_id_d;
    end
  end

  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;
  assign o_last  = o_last_q;
  assign o_id    = o_id_q;

  a_ready_onehot0 : assert property (@(posedge clock) disable iff (!reset_n)
    $onehot0(i_ready));

  a_hold_stable : assert property (@(posedge clock) disable iff (!reset_n)
    (o_valid && !o_ready) |=> (o_valid && $stable(o_data) && $stable(o_last) && $stable(o_id)));

  a_id_range : assert property (@(posedge clock) disable iff (!reset_n)
    (int'(o_id) < N_REQ));

endmodule

// File: tb/tb_kw_stream_rr_arbiter.sv
// Bench for kw_stream_rr_arbiter: directed scenarios plus random traffic against a queue-based reference model.
module tb_kw_stream_rr_arbiter;
  import kw_stream_pkg::*;

  localparam int N    = 4;
  localparam int DW   = 16;
  localparam bit LOCK = 1'b1;

  logic            clock = 1'b0;
  logic            reset_n;
  logic [N-1:0]    i_valid;
  logic [N-1:0]    i_ready;
  logic [N-1:0]    i_last;
  logic [N*DW-1:0] i_data;
  logic            o_valid;
  logic            o_ready;
  logic [DW-1:0]   o_data;
  logic            o_last;
  kw_id_t          o_id;

  always #5 clock = ~clock;

  kw_stream_rr_arbiter #(
    .N_REQ        (N),
    .DATA_WIDTH   (DW),
    .LOCK_PACKETS (LOCK)
  ) u_dut (
    .clock   (clock),
    .reset_n (reset_n),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_last  (i_last),
    .i_data  (i_data),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_last  (o_last),
    .o_id    (o_id)
  );

  typedef struct packed {
    kw_id_t        id;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t         exp_q[$];
  int            obs_id[$];
  logic [DW-1:0] obs_data[$];
  int            obs_cyc[$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc_cnt  = 0;

  // Reference model state: arbitration rules expressed with plain integers.
  int           m_ptr     = 0;
  bit           m_lock    = 1'b0;
  int           m_lock_id = 0;
  int           m_g;
  int           m_k;
  bit           m_any;
  bit           m_free;
  logic [N-1:0] m_rdy;
  beat_t        m_beat;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s at %0t: actual 0x%0h required 0x%0h", name, $time, act, req);
    end
  endfunction

  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  // Monitor: whatever the DUT presents must match the oldest predicted beat.
  always @(negedge clock) begin
    if (reset_n) begin
      chk("o_valid", o_valid, exp_q.size() != 0);
      if (o_valid && exp_q.size() != 0) begin
        chk("o_id", o_id, exp_q[0].id);
        chk("o_data", o_data, exp_q[0].data);
        chk("o_last", o_last, exp_q[0].last);
        if (o_ready) begin
          obs_id.push_back(int'(o_id));
          obs_data.push_back(o_data);
          obs_cyc.push_back(cyc_cnt);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Model: runs just after the monitor so the queue reflects whether the output slot is free.
  always @(negedge clock) begin
    #1;
    if (!reset_n) begin
      exp_q.delete();
      m_ptr     = 0;
      m_lock    = 1'b0;
      m_lock_id = 0;
      chk("rst_i_ready", i_ready, '0);
      chk("rst_o_valid", o_valid, 1'b0);
    end else begin
      m_free = (exp_q.size() == 0);
      m_any  = 1'b0;
      m_g    = 0;
      if (m_lock) begin
        m_any = 1'b1;
        m_g   = m_lock_id;
      end else begin
        for (int off = 0; off < N; off++) begin
          m_k = (m_ptr + off) % N;
          if (!m_any && i_valid[m_k]) begin
            m_any = 1'b1;
            m_g   = m_k;
          end
        end
      end
      m_rdy = '0;
      if (m_free && m_any) m_rdy[m_g] = 1'b1;
      chk("i_ready", i_ready, m_rdy);
      if (m_free && m_any && i_valid[m_g]) begin
        m_beat.id   = kw_id_t'(m_g);
        m_beat.data = i_data[m_g*DW +: DW];
        m_beat.last = i_last[m_g];
        exp_q.push_back(m_beat);
        if (!LOCK || i_last[m_g]) m_ptr = (m_g + 1) % N;
        if (LOCK) begin
          m_lock    = !i_last[m_g];
          m_lock_id = m_g;
        end
      end
    end
  end

  task automatic cyc(input logic [N-1:0] v, input logic [N-1:0] l, input logic rdy);
    i_valid = v;
    i_last  = l;
    o_ready = rdy;
    for (int k = 0; k < N; k++) i_data[k*DW +: DW] = DW'($urandom);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    i_valid = '1;
    i_last  = '1;
    o_ready = 1'b1;
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    reset_n = 1'b1;
  endtask

  task automatic clear_obs();
    obs_id.delete();
    obs_data.delete();
    obs_cyc.delete();
  endtask

  task automatic check_seq(input string name, input int exp[8], input int n);
    chk({name, "_len"}, obs_id.size(), n);
    for (int i = 0; i < n && i < obs_id.size(); i++) chk({name, "_id"}, obs_id[i], exp[i]);
  endtask

  initial begin
    reset_n = 1'b0;
    i_valid = '1;
    i_last  = '1;
    i_data  = '0;
    o_ready = 1'b1;
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    chk("reset_o_valid", o_valid, 1'b0);
    chk("reset_o_data", o_data, '0);
    chk("reset_o_last", o_last, 1'b0);
    chk("reset_o_id", o_id, '0);
    chk("reset_i_ready", i_ready, '0);

    // Release with everything valid: id 0 first, output appears one cycle later.
    reset_n = 1'b1;
    clear_obs();
    #1;
    chk("t1_first_ready", i_ready, 4'b0001);
    chk("t1_o_valid_low", o_valid, 1'b0);
    @(posedge clock);
    #1;
    chk("t1_o_valid_high", o_valid, 1'b1);
    chk("t1_o_id", o_id, 0);
    repeat (5) cyc('1, '1, 1'b1);
    repeat (2) cyc('0, '0, 1'b1);
    check_seq("t2", '{0, 1, 2, 3, 0, 1, 0, 0}, 6);
    if (obs_cyc.size() >= 6) chk("t2_no_bubble", obs_cyc[5] - obs_cyc[0], 5);

    // Requester 1 sends a 3-beat packet while the others keep requesting.
    do_reset();
    clear_obs();
    cyc(4'b0001, '1, 1'b1);
    cyc('1, 4'b1101, 1'b1);
    cyc('1, 4'b1101, 1'b1);
    cyc('1, '1, 1'b1);
    cyc('1, '1, 1'b1);
    repeat (2) cyc('0, '0, 1'b1);
    check_seq("t3", '{0, 1, 1, 1, 2, 0, 0, 0}, 5);

    // Locked requester 1 goes idle for two cycles mid-packet.
    do_reset();
    clear_obs();
    cyc(4'b0001, '1, 1'b1);
    cyc('1, 4'b1101, 1'b1);
    cyc(4'b1101, 4'b1101, 1'b1);
    cyc(4'b1101, 4'b1101, 1'b1);
    cyc('1, '1, 1'b1);
    cyc('1, '1, 1'b1);
    repeat (2) cyc('0, '0, 1'b1);
    check_seq("t4", '{0, 1, 1, 2, 0, 0, 0, 0}, 4);

    // Output stalled for five cycles holding 0xBEEF.
    do_reset();
    clear_obs();
    i_valid = 4'b0001;
    i_last  = '1;
    o_ready = 1'b1;
    for (int k = 0; k < N; k++) i_data[k*DW +: DW] = DW'($urandom);
    i_data[DW-1:0] = 16'hBEEF;
    @(posedge clock);
    #1;
    repeat (5) begin
      cyc('1, '1, 1'b0);
      chk("t5_hold_data", o_data, 16'hBEEF);
      chk("t5_ready_low", i_ready, '0);
    end
    cyc('1, '1, 1'b1);
    cyc('1, '1, 1'b1);
    repeat (2) cyc('0, '0, 1'b1);
    check_seq("t5", '{0, 1, 2, 0, 0, 0, 0, 0}, 3);
    if (obs_data.size() >= 1) chk("t5_beef", obs_data[0], 16'hBEEF);

    // Reset in the middle of a packet from requester 2.
    do_reset();
    cyc(4'b0100, 4'b0000, 1'b1);
    cyc(4'b0100, 4'b0000, 1'b1);
    reset_n = 1'b0;
    i_valid = 4'b1000;
    i_last  = '1;
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    reset_n = 1'b1;
    clear_obs();
    #1;
    chk("t6_ready_after_reset", i_ready, 4'b1000);
    @(posedge clock);
    #1;
    repeat (2) cyc('0, '0, 1'b1);
    check_seq("t6", '{3, 0, 0, 0, 0, 0, 0, 0}, 1);

    // Random traffic with random backpressure and rare resets.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] v;
      logic [N-1:0] l;
      for (int k = 0; k < N; k++) begin
        v[k] = ($urandom_range(0, 9) < 6);
        l[k] = ($urandom_range(0, 9) < 4);
      end
      if ($urandom_range(0, 999) == 0) begin
        reset_n = 1'b0;
        cyc(v, l, 1'b1);
        reset_n = 1'b1;
      end else begin
        cyc(v, l, ($urandom_range(0, 3) != 0));
      end
    end
    repeat (4) cyc('0, '0, 1'b1);
    chk("final_drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
